// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//
// This is the ID-stage control for the PC unit. It decodes the instruction
// held in IF/ID and resolves beq/bne by comparing the register operands. It
// then produces the redirect encoding that the PC consumes.
//
// A two-entry scoreboard (EX, MEM) tracks in-flight destination registers.
// A branch or jr whose source is still being produced stalls the front end.
// Every taken redirect flushes IF/ID, because there is no delay slot.
//
// Ports:
//   Clk         rising-edge clock
//   PcReSet     asynchronous active-high reset
//   Instr       IF/ID instruction word
//   InstrValid  IF/ID holds a real instruction (otherwise treated as a nop)
//   RsData      register file read of Instr[25:21]
//   RtData      register file read of Instr[20:16]
//   Branch      010 beq, 001 bne, 011 j/jal, 111 jr, 000 sequential
//   PcSel       conditional branch taken
//   Address     sign-extended Instr[15:0] (the PC applies the <<2)
//   JumpTarget  Instr[25:0]
//   JrTarget    RsData
//   Bobbles     hold PC and IF/ID and inject a bubble into EX
//   IfIdFlush   clear IF/ID at the next edge
//   StallCount  saturating count of cycles spent with Bobbles high
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             PcReSet,
    input  logic [31:0]      Instr,
    input  logic             InstrValid,
    input  logic [31:0]      RsData,
    input  logic [31:0]      RtData,
    output logic [2:0]       Branch,
    output logic             PcSel,
    output logic [31:0]      Address,
    output logic [25:0]      JumpTarget,
    output logic [31:0]      JrTarget,
    output logic             Bobbles,
    output logic             IfIdFlush,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_JUMP = 3'b011;
    localparam logic [2:0] BR_JR   = 3'b111;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
    } sb_entry_t;

    sb_entry_t        sb_ex_q, sb_ex_d;
    sb_entry_t        sb_mem_q, sb_mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_beq, is_bne, is_j, is_jal, is_jr;
    logic       dst_valid;
    logic [4:0] dst;
    logic       rs_hit, rt_hit;
    logic       hazard;

    assign op    = Instr[31:26];
    assign funct = Instr[5:0];
    assign rs    = Instr[25:21];
    assign rt    = Instr[20:16];
    assign rd    = Instr[15:11];

    // Decode. An invalid slot decodes to nothing, so it neither redirects
    // nor occupies a scoreboard entry. Writes to $0 are dropped here, so
    // $0 can never match a scoreboard entry and never causes a stall.
    always_comb begin
        is_beq    = InstrValid && (op == OP_BEQ);
        is_bne    = InstrValid && (op == OP_BNE);
        is_j      = InstrValid && (op == OP_J);
        is_jal    = InstrValid && (op == OP_JAL);
        is_jr     = InstrValid && (op == OP_RTYPE) && (funct == FN_JR);
        dst_valid = 1'b0;
        dst       = 5'd0;
        if (InstrValid) begin
            if ((op == OP_RTYPE) && (funct != FN_JR)) begin
                dst_valid = 1'b1;
                dst       = rd;
            end else if ((op == OP_LW) || (op[5:3] == 3'b001)) begin
                dst_valid = 1'b1;
                dst       = rt;
            end else if (op == OP_JAL) begin
                dst_valid = 1'b1;
                dst       = 5'd31;
            end
        end
        if (dst == 5'd0) begin
            dst_valid = 1'b0;
        end
    end

    // Only branch operands are checked. ALU forwarding is handled by the
    // datapath, so other instructions never stall here.
    always_comb begin
        rs_hit = (rs != 5'd0) &&
                 ((sb_ex_q.valid  && (sb_ex_q.dst  == rs)) ||
                  (sb_mem_q.valid && (sb_mem_q.dst == rs)));
        rt_hit = (rt != 5'd0) &&
                 ((sb_ex_q.valid  && (sb_ex_q.dst  == rt)) ||
                  (sb_mem_q.valid && (sb_mem_q.dst == rt)));
        hazard = ((is_beq || is_bne || is_jr) && rs_hit) ||
                 ((is_beq || is_bne) && rt_hit);
    end

    // Redirect outputs. A stalled instruction must not redirect yet; it is
    // resolved in the first cycle its operands are safe to read.
    always_comb begin
        Bobbles    = hazard;
        Branch     = BR_SEQ;
        PcSel      = 1'b0;
        Address    = {{16{Instr[15]}}, Instr[15:0]};
        JumpTarget = Instr[25:0];
        JrTarget   = RsData;
        if (!hazard) begin
            if (is_beq) begin
                Branch = BR_BEQ;
                PcSel  = (RsData == RtData);
            end else if (is_bne) begin
                Branch = BR_BNE;
                PcSel  = (RsData != RtData);
            end else if (is_j || is_jal) begin
                Branch = BR_JUMP;
            end else if (is_jr) begin
                Branch = BR_JR;
            end
        end
        IfIdFlush  = PcSel || (Branch == BR_JUMP) || (Branch == BR_JR);
        StallCount = stall_cnt_q;
    end

    // Scoreboard shift and stall counter. A stalled ID instruction enters
    // EX as a bubble, so it does not claim its destination until it really
    // issues.
    always_comb begin
        sb_mem_d    = sb_ex_q;
        sb_ex_d     = '0;
        stall_cnt_d = stall_cnt_q;
        if (!hazard) begin
            sb_ex_d.valid = dst_valid;
            sb_ex_d.dst   = dst;
        end
        if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge PcReSet) begin
        if (PcReSet) begin
            sb_ex_q     <= '0;
            sb_mem_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

- ID-stage control block that drives the PC unit's redirect and stall inputs.
- Decodes the instruction held in IF/ID and resolves beq/bne by comparing register operands.
- Generates the `Branch`/`PcSel`/`Address`/`JumpTarget`/`JrTarget`/`Bobbles` encoding consumed by the PC.
- Tracks the two in-flight producers (EX, MEM) in a scoreboard to stall on read-after-write hazards, and flushes IF/ID on every taken redirect (no delay slot).

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `Clk` input 1: clock, rising edge.
- `PcReSet` input 1: reset, asynchronous, active-high.
- `Instr` input 32: IF/ID instruction.
- `InstrValid` input 1: IF/ID holds a real instruction.
- `RsData` input 32: register file read of `Instr[25:21]`.
- `RtData` input 32: register file read of `Instr[20:16]`.
- `Branch` output 3: 010 beq, 001 bne, 011 j/jal, 111 jr, 000 sequential.
- `PcSel` output 1: conditional branch taken.
- `Address` output 32: sign-extended `Instr[15:0]`; the PC shifts it left by 2.
- `JumpTarget` output 26: `Instr[25:0]`.
- `JrTarget` output 32: `RsData`.
- `Bobbles` output 1: hold PC and IF/ID; inject a bubble into EX.
- `IfIdFlush` output 1: clear IF/ID at the next edge.
- `StallCount` output CNT_W: saturating count of cycles with `Bobbles`=1.

## Operation
Decode, gated by `InstrValid`; an invalid instruction decodes as a nop:
- beq: op 000100. bne: op 000101. j: op 000010. jal: op 000011.
- jr: op 000000 with funct 001000.

Destination rule:
- R-type other than jr: rd.
- lw (100011) and op 001xxx: rt.
- jal: 31.
- All others: none.
- Destination 0 counts as none.

Source use:
- beq/bne read rs and rt.
- jr reads rs.
- No other instruction is checked; ALU hazards are the datapath's concern.

Scoreboard:
- Two entries, `sb_ex` then `sb_mem`, each holding {valid, dst[4:0]}.
- Each edge: `sb_mem` <= `sb_ex`.
- `sb_ex` <= the ID instruction's destination, or invalid when `Bobbles`=1 or the ID instruction is invalid.

Hazard:
- `Bobbles`=1 when the ID instruction is a branch/jr and any used source equals a valid scoreboard dst.
- Consequence: a producer immediately ahead costs 2 stall cycles; one two ahead costs 1.

Redirect outputs (combinational):
- While `Bobbles`=1: `Branch`=000, `PcSel`=0, `IfIdFlush`=0.
- Otherwise:
  - beq: `PcSel` = (`RsData`==`RtData`).
  - bne: `PcSel` = (`RsData`!=`RtData`).
  - j/jal and jr: `Branch` set per the encoding above, `PcSel`=0.
- `IfIdFlush`=1 iff `PcSel`=1, `Branch`=011, or `Branch`=111.
- `Address`, `JumpTarget` and `JrTarget` are always driven from `Instr` and `RsData`, whether or not a redirect occurs.

Counter:
- `StallCount` increments each edge with `Bobbles`=1.
- It saturates at all-ones.

## Timing
- Reset (asynchronous): scoreboard entries invalid, `StallCount`=0.
- With `Instr`=0 and `InstrValid`=0 during reset: `Branch`=000, `PcSel`=0, `Bobbles`=0, `IfIdFlush`=0, `Address`=0, `JumpTarget`=0, `JrTarget`=`RsData`.
- All outputs except `StallCount` are combinational from `Instr`, `RsData`, `RtData` and the scoreboard, with zero latency. The PC samples them at the same edge the scoreboard advances.
- Stall hold: the ID instruction is held; the redirect is resolved in the first cycle with `Bobbles`=0.
- Taken redirect: `IfIdFlush` is high for exactly that cycle. The next ID cycle sees the flushed nop, so no wrong-path instruction enters the scoreboard.
- Not-taken beq/bne: no flush; the next instruction proceeds.
- Reset mid-stall: scoreboard cleared immediately, `Bobbles` drops in the same cycle, and the counter clears.
- Boundary cases:
  - Hazard on `$0` never stalls.
  - jal writing 31 followed by jr `$31` stalls 1 cycle, because the flush bubble intervenes.
  - Simultaneous EX and MEM matches stall until the EX entry drains (2 cycles).

## Test plan
- Reset with an unknown `Instr`, then `InstrValid`=0: all control outputs 0 and `StallCount`=0, before any clock edge.
- `addi $8` then `beq $8,$9` (equal data): `Bobbles`=1 for 2 cycles, then `Branch`=010, `PcSel`=1, `IfIdFlush`=1 for one cycle, and `StallCount`=2.
- `lw $9`, an independent instruction, then `bne $8,$9` (unequal data): 1 stall cycle, then `Branch`=001, `PcSel`=1.
- `jal` target 0x0000040 then `jr $31` with `RsData`=0x3008:
  - jal cycle: `Branch`=011, `JumpTarget`=0x0000040, flush.
  - jr: 1 stall cycle, then `Branch`=111, `JrTarget`=0x3008.
- `beq $0,$0` with offset 0xFFFF right after a write to `$0`: no stall, `Address`=0xFFFFFFFF, `PcSel`=1.
- Assert `PcReSet` during the second cycle of a 2-cycle stall: `Bobbles` falls the same cycle and `StallCount`=0.
